// File: rtl/axis_fetch_addr_gen.sv
// Fetch-address generator: emits a strided address stream on an AXI-Stream
// master port and flushes the downstream FIFO with a one-cycle invalidate
// pulse whenever a redirect loads a new base address.
module axis_fetch_addr_gen #(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter logic [TDATA_WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [TDATA_WIDTH-1:0] STRIDE = TDATA_WIDTH'(4),
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [TDATA_WIDTH-1:0] redirect_addr,
    input  logic                   halt,
    output logic                   mif_tvalid,
    output logic [TDATA_WIDTH-1:0] mif_tdata,
    input  logic                   mif_tready,
    output logic                   invalidate,
    output logic [CNT_WIDTH-1:0]   beat_count
);

    typedef enum logic [1:0] {
        StReset,
        StRun,
        StHalt
    } state_e;

    state_e                 state_q, state_d;
    logic                   tvalid_q, tvalid_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                   inval_q, inval_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   handshake;

    assign handshake = tvalid_q & mif_tready;

    // Next-state and next-output computation; redirect overrides address/count updates.
    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        count_d  = count_q;
        inval_d  = 1'b0;

        unique case (state_q)
            StReset: begin
                state_d = halt ? StHalt : StRun;
            end
            StRun: begin
                if (handshake) begin
                    tdata_d = tdata_q + STRIDE;
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    // A pending beat is never withdrawn: halt is only honoured on acceptance.
                    if (halt) begin
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                state_d = halt ? StHalt : StRun;
            end
            default: state_d = StReset;
        endcase

        // A beat accepted in the redirect cycle is flushed downstream, so it
        // neither advances the address nor counts.
        if (redirect_valid) begin
            tdata_d = redirect_addr;
            count_d = '0;
            inval_d = 1'b1;
        end

        tvalid_d = (state_d == StRun);
    end

    // Registered state and outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StReset;
            tvalid_q <= 1'b0;
            tdata_q  <= RESET_ADDR;
            inval_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            inval_q  <= inval_d;
            count_q  <= count_d;
        end
    end

    assign mif_tvalid = tvalid_q;
    assign mif_tdata  = tdata_q;
    assign invalidate = inval_q;
    assign beat_count = count_q;

endmodule

// File: tb/tb_axis_fetch_addr_gen.sv
// Directed bench for axis_fetch_addr_gen: inputs change #1 after the rising
// edge, outputs are checked right after that, expected values hand-computed.
module tb_axis_fetch_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        halt;
    logic        mif_tvalid;
    logic [31:0] mif_tdata;
    logic        mif_tready;
    logic        invalidate;
    logic [7:0]  beat_count;

    int vectors = 0;
    int miscompares = 0;

    axis_fetch_addr_gen #(
        .TDATA_WIDTH(32),
        .RESET_ADDR (32'h0),
        .STRIDE     (32'h4),
        .CNT_WIDTH  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .mif_tvalid    (mif_tvalid),
        .mif_tdata     (mif_tdata),
        .mif_tready    (mif_tready),
        .invalidate    (invalidate),
        .beat_count    (beat_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] d,
                           input logic inv, input logic [7:0] c);
        chk({tag, ".tvalid"}, {31'b0, mif_tvalid}, {31'b0, v});
        chk({tag, ".tdata"}, mif_tdata, d);
        chk({tag, ".invalidate"}, {31'b0, invalidate}, {31'b0, inv});
        chk({tag, ".beat_count"}, {24'b0, beat_count}, {24'b0, c});
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; mif_tready = 1'b1;

        // Reset held three cycles
        tick(); tick(); tick();
        chk_all("reset", 1'b0, 32'h0, 1'b0, 8'd0);

        // Release: first beat is RESET_ADDR
        rst = 1'b0;
        tick(); chk_all("rel0", 1'b1, 32'h0, 1'b0, 8'd0);
        tick(); chk_all("rel1", 1'b1, 32'h4, 1'b0, 8'd1);
        tick(); chk_all("rel2", 1'b1, 32'h8, 1'b0, 8'd2);

        // Backpressure with 0x8 pending
        mif_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); chk_all("bp_hold", 1'b1, 32'h8, 1'b0, 8'd2);
        end
        mif_tready = 1'b1;
        tick(); chk_all("bp_acc", 1'b1, 32'hC, 1'b0, 8'd3);
        tick(); chk_all("stream4", 1'b1, 32'h10, 1'b0, 8'd4);

        // Redirect coincident with handshake of 0x10
        redirect_valid = 1'b1; redirect_addr = 32'h1000;
        tick(); chk_all("redir", 1'b1, 32'h1000, 1'b1, 8'd0);
        redirect_valid = 1'b0;
        tick(); chk_all("redir+1", 1'b1, 32'h1004, 1'b0, 8'd1);
        tick(); chk_all("redir+2", 1'b1, 32'h1008, 1'b0, 8'd2);

        // Back-to-back redirects: last one wins, invalidate stays high
        redirect_valid = 1'b1; redirect_addr = 32'h2000;
        tick(); chk_all("b2b0", 1'b1, 32'h2000, 1'b1, 8'd0);
        redirect_addr = 32'h3000;
        tick(); chk_all("b2b1", 1'b1, 32'h3000, 1'b1, 8'd0);
        redirect_valid = 1'b0;
        tick(); chk_all("b2b2", 1'b1, 32'h3004, 1'b0, 8'd1);

        // Load 0x20 under backpressure (tdata changes only with invalidate)
        redirect_valid = 1'b1; redirect_addr = 32'h20; mif_tready = 1'b0;
        tick(); chk_all("ld20", 1'b1, 32'h20, 1'b1, 8'd0);
        // Halt while 0x20 pending: beat must not be withdrawn
        redirect_valid = 1'b0; halt = 1'b1;
        tick(); chk_all("halt_pend0", 1'b1, 32'h20, 1'b0, 8'd0);
        tick(); chk_all("halt_pend1", 1'b1, 32'h20, 1'b0, 8'd0);
        mif_tready = 1'b1;
        tick(); chk_all("halt_acc", 1'b0, 32'h24, 1'b0, 8'd1);
        tick(); chk_all("halt_idle", 1'b0, 32'h24, 1'b0, 8'd1);
        // Redirect during halt
        redirect_valid = 1'b1; redirect_addr = 32'h40;
        tick(); chk_all("halt_redir", 1'b0, 32'h40, 1'b1, 8'd0);
        redirect_valid = 1'b0;
        tick(); chk_all("halt_redir+1", 1'b0, 32'h40, 1'b0, 8'd0);
        halt = 1'b0;
        tick(); chk_all("unhalt", 1'b1, 32'h40, 1'b0, 8'd0);
        tick(); chk_all("unhalt+1", 1'b1, 32'h44, 1'b0, 8'd1);

        // Address wrap
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        tick(); chk_all("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b1, 8'd0);
        redirect_valid = 1'b0;
        tick(); chk_all("wrap1", 1'b1, 32'h0, 1'b0, 8'd1);

        // Counter saturation: 254 at 254 beats, 255 from then on up to 300 beats
        for (int i = 0; i < 253; i++) tick();
        chk({"sat254", ".beat_count"}, {24'b0, beat_count}, 32'd254);
        chk({"sat254", ".tdata"}, mif_tdata, 32'd254 * 32'd4 - 32'd4);
        tick();
        chk({"sat255", ".beat_count"}, {24'b0, beat_count}, 32'd255);
        for (int i = 0; i < 45; i++) tick();
        chk({"sat300", ".beat_count"}, {24'b0, beat_count}, 32'd255);
        chk({"sat300", ".tdata"}, mif_tdata, 32'd300 * 32'd4 - 32'd4);

        // Reset together with redirect: reset wins
        rst = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h5000;
        tick(); chk_all("rst_redir", 1'b0, 32'h0, 1'b0, 8'd0);
        rst = 1'b0; redirect_valid = 1'b0;
        tick(); chk_all("rst_rel", 1'b1, 32'h0, 1'b0, 8'd0);

        // Release reset with halt held: goes straight to HALT
        rst = 1'b1;
        tick();
        rst = 1'b0; halt = 1'b1;
        tick(); chk_all("rst_halt", 1'b0, 32'h0, 1'b0, 8'd0);
        halt = 1'b0;
        tick(); chk_all("rst_halt_rel", 1'b1, 32'h0, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_fetch_addr_gen.md
# axis_fetch_addr_gen

AXI-Stream transmitter that generates a sequential address stream (RESET_ADDR, +STRIDE, +2·STRIDE, …) and drives both the slave side and the `invalidate` input of a downstream `axis_sync_fifo`. A redirect loads a new base address and flushes the downstream FIFO with a one-cycle `invalidate` pulse. It is the producing end of the fetch-address path, so the FIFO never receives stale addresses after a control-flow change.

## Interface
Parameters:
- `TDATA_WIDTH`, 32, address/data width
- `RESET_ADDR`, 0, first address emitted after reset
- `STRIDE`, 4, increment applied after each accepted beat
- `CNT_WIDTH`, 8, width of the beat counter

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `redirect_valid`  in  1  load `redirect_addr` as the next address; single-cycle strobe
- `redirect_addr`  in  TDATA_WIDTH  new base address
- `halt`  in  1  suppress issuing new beats
- `mif_tvalid`  out  1  AXIS valid
- `mif_tdata`  out  TDATA_WIDTH  AXIS data (address)
- `mif_tready`  in  1  AXIS ready
- `invalidate`  out  1  flush pulse to the downstream FIFO
- `beat_count`  out  CNT_WIDTH  accepted beats since the last redirect or reset, saturating

## Operation
- All outputs are registered. States are RESET, RUN and HALT.
- RESET state (while `rst`=1):
  - `mif_tvalid`=0, `mif_tdata`=RESET_ADDR, `invalidate`=0, `beat_count`=0.
  - The next state is RUN if `halt`=0, otherwise HALT.
- RUN state:
  - `mif_tvalid`=1.
  - On a handshake (`mif_tvalid`&`mif_tready`), `mif_tdata` <= `mif_tdata`+STRIDE. The add is modulo 2^TDATA_WIDTH, so it wraps silently.
  - On a handshake, `beat_count` increments and saturates at all-ones.
- HALT entry and exit:
  - `halt` is sampled only when no beat is pending, or in the same cycle as a handshake.
  - An asserted, unaccepted beat is never withdrawn because of `halt`. It holds until accepted, and then `mif_tvalid` drops.
  - RUN→HALT happens when `halt`=1 and (`mif_tvalid`=0 or a handshake occurs).
  - HALT→RUN happens when `halt`=0.
- Redirect (`redirect_valid`=1 in cycle N) has the highest priority of all events in that cycle:
  - In N+1: `mif_tdata`=`redirect_addr`, `invalidate`=1 for exactly one cycle, `beat_count`=0.
  - In N+1, `mif_tvalid` is 1 unless the state in N+1 is HALT.
  - A handshake in cycle N still counts as an AXIS transfer. That beat enters the FIFO at the N+1 edge and is flushed by the N+1 `invalidate`. It is not counted in `beat_count`, and no +STRIDE is applied.
  - Sole permitted AXIS-stability exception: `mif_tdata` may change while `mif_tvalid`=1 with no handshake, only in a cycle where `invalidate`=1.
- Back-to-back redirects in N and N+1: `invalidate` stays high in N+1 and N+2. The last redirect address wins.
- Reset during any state returns to RESET on the next edge. This discards a pending beat and any redirect arriving in the same cycle as reset.

## Timing
- Reset release: first cycle after `rst` falls (with `halt`=0) gives `mif_tvalid`=1 and `mif_tdata`=RESET_ADDR.
- With `mif_tready` held at 1, one beat is accepted per cycle. There are no bubbles.
- Address update latency is one cycle after the handshake.
- Redirect to new address on `mif_tdata` is one cycle.
- Redirect to `invalidate` is one cycle, coincident with the new address.
- `halt` to `mif_tvalid` low is one cycle, provided no beat is pending.
- `halt` deassert to `mif_tvalid` high is one cycle.
- No combinational path exists from any input to any output.

## Test plan
- **Reset/stream:** hold `rst` 3 cycles, then release with `mif_tready`=1.
  - `mif_tdata` must read 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - `beat_count` must read 0, 1, 2, 3, 4.
- **Backpressure:** `mif_tready`=0 for 5 cycles, with tvalid high and tdata=0x8.
  - `mif_tdata` must stay 0x8 and `mif_tvalid` stay 1.
  - Raising ready gives 0x8 accepted, then 0xC next cycle.
- **Redirect with handshake:** `redirect_valid`=1 with `redirect_addr`=0x1000 in the same cycle as a handshake of 0x10.
  - Next cycle: tdata=0x1000, `invalidate`=1 for one cycle, `beat_count`=0.
  - Then 0x1004.
- **Halt:** `halt`=1 while 0x20 is pending and ready=0.
  - 0x20 must stay valid until ready=1, then `mif_tvalid`=0.
  - A redirect to 0x40 during halt gives `invalidate` pulse, tdata=0x40, tvalid=0.
  - Releasing halt gives tvalid=1 with 0x40 the next cycle.
- **Wrap/saturation:** redirect to 0xFFFFFFFC.
  - Stream gives 0xFFFFFFFC, then 0x00000000.
  - After 300 accepted beats, `beat_count`=255.
- **Reset mid-operation:** `rst` asserted together with `redirect_valid`.
  - Next cycle: tvalid=0, tdata=RESET_ADDR, `invalidate`=0.
